rr_arb_mux: RTL and testbench

- Parametrised N-channel, WIDTH-bit arbitrating multiplexer with a registered output and a valid/ready handshake on every side.
- Successor to the plain 2:1 select mux: channel selection is decided internally by round-robin arbitration, not by an external select line.
- Adds optional multi-beat grant locking.
- Main use: sharing one unified memory port between instruction fetch (channel 0) and the MEM stage (channel 1), and any future N-way shared resource.

---
 rtl/rr_arb_mux.sv | 108 ++++++++++
 tb/tb_rr_arb_mux.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rr_arb_mux.sv
// rr_arb_mux: N-channel, WIDTH-bit arbitrating multiplexer with a registered
// output stage. Requesters are selected by round-robin arbitration. A
// requester can keep the grant across several beats by holding req_lock.
//
// Handshake: a beat moves on any interface in a cycle where valid and ready
// are both 1 at the rising edge of clk. A requester holds valid and data
// stable until it sees ready. req_ready is combinational from req_valid and
// out_ready, so the arbiter never asserts ready on a channel without a valid.
//
// Ports:
//   clk        rising-edge clock
//   rst_n      synchronous active-low reset
//   req_valid  [N]        channel i presents a beat
//   req_data   [N*WIDTH]  channel i data in bits [i*WIDTH +: WIDTH]
//   req_lock   [N]        keep the grant on channel i after this beat
//   req_ready  [N]        channel i's beat is accepted this cycle
//   out_valid             the output register holds a beat
//   out_data   [WIDTH]    registered data of the granted channel
//   out_sel    [SELW]     index of the channel whose beat is in out_data
//   out_ready             downstream consumes the beat when out_valid=1
module rr_arb_mux #(
    parameter int WIDTH = 32,
    parameter int N     = 2,
    parameter int SELW  = (N > 1) ? $clog2(N) : 1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [N-1:0]       req_valid,
    input  logic [N*WIDTH-1:0] req_data,
    input  logic [N-1:0]       req_lock,
    output logic [N-1:0]       req_ready,
    output logic               out_valid,
    output logic [WIDTH-1:0]   out_data,
    output logic [SELW-1:0]    out_sel,
    input  logic               out_ready
);

    logic [SELW-1:0] ptr;
    logic [SELW-1:0] lock_ch;
    logic            lock_active;

    logic [N-1:0]    grant;
    logic [SELW-1:0] gidx;
    logic [SELW-1:0] cidx;
    logic [SELW-1:0] ptr_next;
    logic            accept;
    logic            transfer;

    // Grant selection. Unlocked, the scan runs from the farthest position
    // back towards ptr so that the valid channel closest to ptr (in
    // ptr, ptr+1, ... order) is the last one written and therefore wins.
    always_comb begin
        grant = '0;
        gidx  = '0;
        cidx  = '0;
        if (lock_active) begin
            // Only the locked channel is eligible, even if it is idle.
            if (req_valid[lock_ch]) begin
                grant[lock_ch] = 1'b1;
                gidx           = lock_ch;
            end
        end else begin
            for (int k = N - 1; k >= 0; k--) begin
                cidx = SELW'((int'(ptr) + k) % N);
                if (req_valid[cidx]) begin
                    grant       = '0;
                    grant[cidx] = 1'b1;
                    gidx        = cidx;
                end
            end
        end
    end

    // The output register can take a new beat when it is empty or being
    // drained this cycle; nothing is accepted while reset is asserted.
    assign accept    = ~out_valid | out_ready;
    assign req_ready = rst_n ? (grant & {N{accept}}) : '0;
    assign transfer  = |req_ready;

    assign ptr_next  = (int'(gidx) == N - 1) ? '0 : gidx + SELW'(1);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_valid   <= 1'b0;
            out_data    <= '0;
            out_sel     <= '0;
            ptr         <= '0;
            lock_active <= 1'b0;
            lock_ch     <= '0;
        end else begin
            if (transfer) begin
                out_valid   <= 1'b1;
                out_data    <= req_data[int'(gidx)*WIDTH +: WIDTH];
                out_sel     <= gidx;
                ptr         <= ptr_next;
                // Lock state only ever follows the channel that transferred.
                lock_active <= req_lock[gidx];
                if (req_lock[gidx]) begin
                    lock_ch <= gidx;
                end
            end else if (out_ready) begin
                // Drain: data and sel keep their last values.
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_rr_arb_mux.sv
// Directed bench for rr_arb_mux: a 2-channel 32-bit instance and a
// 4-channel 8-bit instance share clock and reset. Inputs change 1 time unit
// after the rising edge; outputs are sampled on the falling edge.
module tb_rr_arb_mux;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n;

    // N=2, WIDTH=32 instance
    logic [1:0]  rv2, rl2, rr2;
    logic [63:0] rd2;
    logic        ov2, or2;
    logic [31:0] od2;
    logic [0:0]  os2;

    // N=4, WIDTH=8 instance
    logic [3:0]  rv4, rl4, rr4;
    logic [31:0] rd4;
    logic        ov4, or4;
    logic [7:0]  od4;
    logic [1:0]  os4;

    int checks   = 0;
    int failures = 0;
    logic [31:0] exp_q[$];

    rr_arb_mux #(.WIDTH(32), .N(2)) u_dut2 (
        .clk(clk), .rst_n(rst_n),
        .req_valid(rv2), .req_data(rd2), .req_lock(rl2), .req_ready(rr2),
        .out_valid(ov2), .out_data(od2), .out_sel(os2), .out_ready(or2)
    );

    rr_arb_mux #(.WIDTH(8), .N(4)) u_dut4 (
        .clk(clk), .rst_n(rst_n),
        .req_valid(rv4), .req_data(rd4), .req_lock(rl4), .req_ready(rr4),
        .out_valid(ov4), .out_data(od4), .out_sel(os4), .out_ready(or4)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        rv2 = '0; rl2 = '0; or2 = 1'b1;
        rv4 = '0; rl4 = '0; or4 = 1'b1;
        step();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        rv2 = 2'b11; rl2 = 2'b00; or2 = 1'b1;
        rd2 = {32'hBBBB1111, 32'hAAAA0000};
        step();
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            checks++;
            if (rr2 !== 2'b00) begin
                failures++; $display("FAIL reset_req_ready cycle=%0d got=%b exp=00", c, rr2);
            end
            checks++;
            if (ov2 !== 1'b0) begin
                failures++; $display("FAIL reset_out_valid cycle=%0d got=%b exp=0", c, ov2);
            end
            checks++;
            if (od2 !== 32'h0) begin
                failures++; $display("FAIL reset_out_data cycle=%0d got=%h exp=0", c, od2);
            end
            checks++;
            if (os2 !== 1'b0) begin
                failures++; $display("FAIL reset_out_sel cycle=%0d got=%0d exp=0", c, os2);
            end
            step();
        end
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (rr2 !== 2'b01) begin
            failures++; $display("FAIL reset_release_ready got=%b exp=01", rr2);
        end
        step();
        rv2 = 2'b00;
    endtask

    task automatic test_round_robin();
        logic [1:0]  er[4];
        logic [0:0]  es[4];
        logic [31:0] e;
        er = '{2'b01, 2'b10, 2'b01, 2'b10};
        es = '{1'b0, 1'b1, 1'b0, 1'b1};
        do_reset();
        rd2 = {32'hBBBB1111, 32'hAAAA0000};
        rv2 = 2'b11; or2 = 1'b1;
        exp_q = {32'hAAAA0000, 32'hBBBB1111, 32'hAAAA0000, 32'hBBBB1111};
        for (int c = 0; c < 5; c++) begin
            if (c == 4) rv2 = 2'b00;
            @(negedge clk);
            if (c < 4) begin
                checks++;
                if (rr2 !== er[c]) begin
                    failures++; $display("FAIL rr_req_ready cycle=%0d got=%b exp=%b", c, rr2, er[c]);
                end
            end
            if (c > 0) begin
                e = exp_q.pop_front();
                checks++;
                if (ov2 !== 1'b1) begin
                    failures++; $display("FAIL rr_out_valid cycle=%0d got=%b exp=1", c, ov2);
                end
                checks++;
                if (od2 !== e) begin
                    failures++; $display("FAIL rr_out_data cycle=%0d got=%h exp=%h", c, od2, e);
                end
                checks++;
                if (os2 !== es[c-1]) begin
                    failures++; $display("FAIL rr_out_sel cycle=%0d got=%0d exp=%0d", c, os2, es[c-1]);
                end
            end
            step();
        end
    endtask

    task automatic test_back_pressure();
        do_reset();
        rd2 = {32'h12345678, 32'hAAAA0000};
        rv2 = 2'b10; or2 = 1'b1;
        @(negedge clk);
        checks++;
        if (rr2 !== 2'b10) begin
            failures++; $display("FAIL bp_first_grant got=%b exp=10", rr2);
        end
        step();
        rv2 = 2'b11; or2 = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            checks++;
            if (od2 !== 32'h12345678) begin
                failures++; $display("FAIL bp_hold_data cycle=%0d got=%h exp=12345678", c, od2);
            end
            checks++;
            if (os2 !== 1'b1 || ov2 !== 1'b1) begin
                failures++; $display("FAIL bp_hold_sel_valid cycle=%0d got=%0d/%b exp=1/1", c, os2, ov2);
            end
            checks++;
            if (rr2 !== 2'b00) begin
                failures++; $display("FAIL bp_stall_ready cycle=%0d got=%b exp=00", c, rr2);
            end
            step();
        end
        or2 = 1'b1;
        @(negedge clk);
        checks++;
        if (rr2 !== 2'b01) begin
            failures++; $display("FAIL bp_release_ready got=%b exp=01", rr2);
        end
        step();
        rv2 = 2'b00;
        @(negedge clk);
        checks++;
        if (ov2 !== 1'b1 || os2 !== 1'b0 || od2 !== 32'hAAAA0000) begin
            failures++; $display("FAIL bp_next_beat got=%b/%0d/%h exp=1/0/aaaa0000", ov2, os2, od2);
        end
        step();
    endtask

    task automatic test_lock();
        logic [1:0]  rv_t[6];
        logic [31:0] d0_t[6];
        logic        l0_t[6];
        logic [1:0]  rr_t[6];
        logic        ov_t[6];
        logic [0:0]  os_t[6];
        logic [31:0] od_t[6];
        rv_t = '{2'b11, 2'b10, 2'b11, 2'b11, 2'b11, 2'b00};
        d0_t = '{32'h0000C000, 32'hDEADBEEF, 32'h0000C001, 32'h0000C002, 32'h00000BAD, 32'h0};
        l0_t = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
        rr_t = '{2'b01, 2'b00, 2'b01, 2'b01, 2'b10, 2'b00};
        ov_t = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
        os_t = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        od_t = '{32'h0, 32'h0000C000, 32'h0000C000, 32'h0000C001, 32'h0000C002, 32'hBBBB1111};
        do_reset();
        or2 = 1'b1;
        for (int c = 0; c < 6; c++) begin
            rv2 = rv_t[c];
            rd2 = {32'hBBBB1111, d0_t[c]};
            rl2 = {1'b0, l0_t[c]};
            @(negedge clk);
            checks++;
            if (rr2 !== rr_t[c]) begin
                failures++; $display("FAIL lock_req_ready cycle=%0d got=%b exp=%b", c, rr2, rr_t[c]);
            end
            if (c > 0) begin
                checks++;
                if (ov2 !== ov_t[c] || os2 !== os_t[c] || od2 !== od_t[c]) begin
                    failures++;
                    $display("FAIL lock_output cycle=%0d got=%b/%0d/%h exp=%b/%0d/%h",
                             c, ov2, os2, od2, ov_t[c], os_t[c], od_t[c]);
                end
            end
            step();
        end
        rl2 = 2'b00;
    endtask

    task automatic test_n4();
        int         g_t[7];
        logic [3:0] rr_t[7];
        g_t  = '{1, 3, 1, 3, 1, 2, 3};
        rr_t = '{4'b0010, 4'b1000, 4'b0010, 4'b1000, 4'b0010, 4'b0100, 4'b1000};
        do_reset();
        rd4 = {8'hA3, 8'hA2, 8'hA1, 8'hA0};
        rv4 = 4'b1010; or4 = 1'b1;
        for (int c = 0; c < 8; c++) begin
            if (c == 4) rv4 = 4'b1110;
            if (c == 7) rv4 = 4'b0000;
            @(negedge clk);
            if (c < 7) begin
                checks++;
                if (rr4 !== rr_t[c]) begin
                    failures++; $display("FAIL n4_req_ready cycle=%0d got=%b exp=%b", c, rr4, rr_t[c]);
                end
            end
            if (c > 0) begin
                checks++;
                if (ov4 !== 1'b1 || os4 !== 2'(g_t[c-1]) || od4 !== 8'(8'hA0 + g_t[c-1])) begin
                    failures++;
                    $display("FAIL n4_output cycle=%0d got=%b/%0d/%h exp=1/%0d/%h",
                             c, ov4, os4, od4, g_t[c-1], 8'(8'hA0 + g_t[c-1]));
                end
            end
            step();
        end
    endtask

    task automatic test_mid_reset();
        do_reset();
        rd2 = {32'h11111111, 32'h22222222};
        rv2 = 2'b10; rl2 = 2'b10; or2 = 1'b1;
        @(negedge clk);
        checks++;
        if (rr2 !== 2'b10) begin
            failures++; $display("FAIL midrst_lock_grant got=%b exp=10", rr2);
        end
        step();
        rv2 = 2'b00; rl2 = 2'b00; or2 = 1'b0;
        rst_n = 1'b0;
        @(negedge clk);
        checks++;
        if (ov2 !== 1'b1 || od2 !== 32'h11111111) begin
            failures++; $display("FAIL midrst_held_beat got=%b/%h exp=1/11111111", ov2, od2);
        end
        step();
        rst_n = 1'b1;
        rv2 = 2'b11; or2 = 1'b1;
        @(negedge clk);
        checks++;
        if (ov2 !== 1'b0 || od2 !== 32'h0) begin
            failures++; $display("FAIL midrst_dropped got=%b/%h exp=0/0", ov2, od2);
        end
        checks++;
        if (rr2 !== 2'b01) begin
            failures++; $display("FAIL midrst_first_grant got=%b exp=01", rr2);
        end
        step();
        rv2 = 2'b00;
        @(negedge clk);
        checks++;
        if (ov2 !== 1'b1 || os2 !== 1'b0 || od2 !== 32'h22222222) begin
            failures++; $display("FAIL midrst_after got=%b/%0d/%h exp=1/0/22222222", ov2, os2, od2);
        end
        step();
    endtask

    initial begin
        rst_n = 1'b0;
        rv2 = '0; rl2 = '0; rd2 = '0; or2 = 1'b1;
        rv4 = '0; rl4 = '0; rd4 = '0; or4 = 1'b1;
        #1;
        test_reset();
        test_round_robin();
        test_back_pressure();
        test_lock();
        test_n4();
        test_mid_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
